// File: rtl/vga_tile_plot_arbiter.sv
// Round-robin arbiter that paints one TILE x TILE square per grant through the
// single VGA adapter pixel port, one pixel per clock, then pulses done for the winner.
module vga_tile_plot_arbiter #(
    parameter int unsigned TILE  = 4,
    parameter int unsigned MAX_X = 160,
    parameter int unsigned MAX_Y = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  req,
    input  logic [23:0] req_x,
    input  logic [23:0] req_y,
    input  logic [8:0]  req_colour,
    output logic [2:0]  done,
    output logic        busy,
    output logic [7:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot
);

    localparam logic [2:0] LAST  = 3'(TILE - 1);
    localparam logic [8:0] LIM_X = 9'(MAX_X);
    localparam logic [8:0] LIM_Y = 9'(MAX_Y);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t      state, state_n;
    logic [1:0]  last_grant, last_grant_n;
    logic [1:0]  gnt, gnt_n;
    logic [7:0]  ox, ox_n, oy, oy_n;
    logic [2:0]  col, col_n;
    logic [2:0]  cx, cx_n, cy, cy_n;

    logic [2:0]  done_n;
    logic        busy_n;
    logic [7:0]  vga_x_n, vga_y_n;
    logic [2:0]  vga_colour_n;
    logic        vga_plot_n;

    logic [1:0]  cand1, cand2, pick;
    logic [7:0]  sel_x, sel_y;
    logic [2:0]  sel_c;

    logic [7:0]  base_x, base_y;
    logic [2:0]  base_c, pcx, pcy;
    logic        emit;
    logic [8:0]  x_sum, y_sum;

    function automatic logic [1:0] next_of(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search starts just after the last winner, so the previous winner is checked last.
    always_comb begin
        cand1 = next_of(last_grant);
        cand2 = next_of(cand1);
        if (req[cand1])
            pick = cand1;
        else if (req[cand2])
            pick = cand2;
        else
            pick = last_grant;
    end

    always_comb begin
        unique case (pick)
            2'd0: begin
                sel_x = req_x[7:0];
                sel_y = req_y[7:0];
                sel_c = req_colour[2:0];
            end
            2'd1: begin
                sel_x = req_x[15:8];
                sel_y = req_y[15:8];
                sel_c = req_colour[5:3];
            end
            default: begin
                sel_x = req_x[23:16];
                sel_y = req_y[23:16];
                sel_c = req_colour[8:6];
            end
        endcase
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        gnt_n        = gnt;
        ox_n         = ox;
        oy_n         = oy;
        col_n        = col;
        cx_n         = cx;
        cy_n         = cy;
        done_n       = '0;
        busy_n       = 1'b0;
        vga_x_n      = vga_x;
        vga_y_n      = vga_y;
        vga_colour_n = vga_colour;
        vga_plot_n   = 1'b0;
        base_x       = ox;
        base_y       = oy;
        base_c       = col;
        pcx          = cx;
        pcy          = cy;
        emit         = 1'b0;

        unique case (state)
            IDLE: begin
                if (req != 3'b000) begin
                    gnt_n        = pick;
                    last_grant_n = pick;
                    ox_n         = sel_x;
                    oy_n         = sel_y;
                    col_n        = sel_c;
                    cx_n         = '0;
                    cy_n         = '0;
                    // First pixel comes straight from the inputs so it is on the outputs next cycle.
                    base_x       = sel_x;
                    base_y       = sel_y;
                    base_c       = sel_c;
                    pcx          = '0;
                    pcy          = '0;
                    emit         = 1'b1;
                    busy_n       = 1'b1;
                    state_n      = DRAW;
                end
            end
            DRAW: begin
                busy_n = 1'b1;
                if (cx == LAST && cy == LAST) begin
                    cx_n    = '0;
                    cy_n    = '0;
                    done_n  = 3'b001 << gnt;
                    state_n = DONE;
                end else begin
                    if (cx == LAST) begin
                        cx_n = '0;
                        cy_n = cy + 3'd1;
                    end else begin
                        cx_n = cx + 3'd1;
                    end
                    pcx  = cx_n;
                    pcy  = cy_n;
                    emit = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        x_sum = {1'b0, base_x} + {6'b0, pcx};
        y_sum = {1'b0, base_y} + {6'b0, pcy};
        if (emit) begin
            vga_x_n      = x_sum[7:0];
            vga_y_n      = y_sum[7:0];
            vga_colour_n = base_c;
            vga_plot_n   = (x_sum < LIM_X) && (y_sum < LIM_Y);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 2'd2;
            gnt        <= '0;
            ox         <= '0;
            oy         <= '0;
            col        <= '0;
            cx         <= '0;
            cy         <= '0;
            done       <= '0;
            busy       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            gnt        <= gnt_n;
            ox         <= ox_n;
            oy         <= oy_n;
            col        <= col_n;
            cx         <= cx_n;
            cy         <= cy_n;
            done       <= done_n;
            busy       <= busy_n;
            vga_x      <= vga_x_n;
            vga_y      <= vga_y_n;
            vga_colour <= vga_colour_n;
            vga_plot   <= vga_plot_n;
        end
    end

endmodule

// File: doc/vga_tile_plot_arbiter.md
# vga_tile_plot_arbiter

Shares the single pixel-write port of the 160x120 VGA adapter between three drawing requesters (wall drawer, tank drawer, eraser). Each requester asks for one square tile to be painted. The block grants requesters round-robin, latches the tile origin and colour, and sequences the TILE x TILE pixel writes one per clock. It then pulses a per-requester completion strobe. It sits between the display logic and the vga_adapter x/y/colour/plot inputs.

## Interface

Parameters:
- TILE, default 4, is the tile edge in pixels. It must be a power of two in the range 1..8.
- MAX_X, default 160, is the screen width. Pixels with x >= MAX_X are suppressed.
- MAX_Y, default 120, is the screen height. Pixels with y >= MAX_Y are suppressed.

Ports:
- clk, input, 1 bit: system clock (CLOCK_50).
- resetn, input, 1 bit: synchronous, active-low reset (KEY[0]).
- req, input, 3 bits: request, one bit per requester. The requester holds the bit high until it sees its done bit.
- req_x, input, 24 bits: tile origin x. Requester i uses bits [8i+7:8i].
- req_y, input, 24 bits: tile origin y. Requester i uses bits [8i+7:8i].
- req_colour, input, 9 bits: tile colour. Requester i uses bits [3i+2:3i].
- done, output, 3 bits: one-cycle completion pulse for the granted requester.
- busy, output, 1 bit: high whenever the state is not IDLE.
- vga_x, output, 8 bits: pixel x to the adapter.
- vga_y, output, 8 bits: pixel y to the adapter.
- vga_colour, output, 3 bits: pixel colour to the adapter.
- vga_plot, output, 1 bit: pixel write enable to the adapter.

## Operation

- State machine states: IDLE, DRAW, DONE.
- IDLE:
  - If req is 0, stay in IDLE.
  - Otherwise grant one requester g, chosen by round-robin. The search order starts at last_grant+1 modulo 3.
  - Latch ox = req_x[g], oy = req_y[g], col = req_colour[g].
  - Clear the counters cx and cy to 0.
  - Update last_grant to g and go to DRAW.
- DRAW: each cycle emits the pixel at (ox+cx, oy+cy).
  - Compute each sum at 9 bits.
  - Set vga_plot=1 only if x_sum < MAX_X and y_sum < MAX_Y. Otherwise vga_plot=0, but the cycle is still consumed.
  - vga_x and vga_y are the low 8 bits of the sums. vga_colour = col.
  - cx increments every cycle. When cx = TILE-1, cx wraps to 0 and cy increments.
  - After the pixel with cx = cy = TILE-1, go to DONE.
- DONE:
  - done[g]=1 for exactly one cycle and vga_plot=0.
  - Then go to IDLE.
- Latched origin and colour are immune to input changes during DRAW and DONE. A req that drops mid-DRAW does not abort the tile; the tile completes and done still pulses.
- The requester drops req in the cycle after it sees done. In the following IDLE cycle that requester has lowest priority, so a stale req cannot starve the others.
- At most one done bit is ever high. done is 0 outside DONE.

## Timing

- All outputs are registered.
- Reset, applied when resetn=0 at a clk edge (including mid-DRAW):
  - State goes to IDLE. done=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
  - cx=cy=0 and last_grant=2, so requester 0 has top priority after reset.
  - No done pulse is issued for an aborted tile.
- Latency, taking edge E0 as the edge at which IDLE samples req!=0:
  - The first pixel is valid on the outputs in the cycle after E0.
  - Pixels occupy TILE*TILE consecutive cycles.
  - done is high in the following cycle.
  - IDLE is re-entered the cycle after that.
- Service period: TILE*TILE+2 cycles per tile (18 for TILE=4). Back-to-back grants are possible with no extra gap.
- busy is high from the cycle after E0 through the DONE cycle inclusive.
- Pixel order is row-major: x fastest, then y.

## Test plan

- Single request:
  - Stimulus: req=001, x=10, y=20, colour=3'b100.
  - Required: 16 plot cycles covering (10..13, 20..23) in row-major order, colour 100. Then done=001 for one cycle. busy is high for 17 cycles.
- Round-robin:
  - Stimulus: req=111 held, each requester deasserting req after its done and reasserting 2 cycles later.
  - Required: grant order after reset is 0,1,2,0,1,2. Each done pulse is 18 cycles after the previous one.
- Clipping:
  - Stimulus: requester 1 with x=158, y=118.
  - Required: only (158,118), (159,118), (158,119), (159,119) are plotted. The other 12 cycles have vga_plot=0. done[1] still pulses at cycle 17.
- Input change mid-draw:
  - Stimulus: change req_x, req_colour and req (dropped) during DRAW.
  - Required: all 16 pixels use the originally latched values, and done fires.
- Reset mid-operation:
  - Stimulus: resetn=0 for 1 cycle at pixel 7 while req=010 is pending.
  - Required: next cycle all outputs are 0, state is IDLE, and no done pulse appears.
  - Then, with req=110, requester 1 is granted first, since requester 0 is not requesting after reset.
- Simultaneous requests after reset:
  - Stimulus: req=110 asserted in the first cycle out of reset.
  - Required: requester 1 is served first, then requester 2.
